// File: rtl/system_top_entity.sv
// system_top_entity: single-cycle RV32I-subset core with instruction ROM and word-addressed data RAM
module system_top_entity #(
  parameter int    IMEM_WORDS = 256,
  parameter int    DMEM_WORDS = 256,
  parameter string IMEM_INIT  = "program.hex"
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] reg1,
  output logic [31:0] reg2,
  output logic [31:0] reg3,
  output logic [31:0] reg4,
  output logic [31:0] reg5,
  output logic [31:0] reg6,
  output logic [31:0] reg7,
  output logic [31:0] reg8,
  output logic [31:0] reg9,
  output logic [31:0] reg10
);
  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);
  localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4 - 1) & ~32'd3;
  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem_q [DMEM_WORDS];
  logic [31:0] rf_q [32];
  logic [31:0] pc_q, pc_d, rd_d, instr, rs1_v, rs2_v, op_b, alu;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opc, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        rd_we, dmem_we, alt, cmp, take, r_ok, sh_ok;
  logic [DA-1:0] ld_idx, st_idx;
  initial begin
    for (int i = 0; i < IMEM_WORDS; i++) imem[i] = 32'h0000_0013;
  end
  assign instr = imem[IA'(pc_q >> 2)];
  assign {f7, rs2, rs1, f3, rd, opc} = instr;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign rs1_v = rf_q[rs1];
  assign rs2_v = rf_q[rs2];
  assign op_b  = (opc == 7'h33) ? rs2_v : imm_i;
  assign alt   = instr[30] & (opc == 7'h33 || f3 == 3'b101);
  assign r_ok  = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
  assign sh_ok = (f3 == 3'b001) ? f7 == 7'h00 : (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
  assign ld_idx = DA'((rs1_v + imm_i) >> 2);
  assign st_idx = DA'((rs1_v + imm_s) >> 2);
  always_comb begin
    case (f3)
      3'b000:  alu = alt ? rs1_v - op_b : rs1_v + op_b;
      3'b001:  alu = rs1_v << op_b[4:0];
      3'b010:  alu = {31'd0, $signed(rs1_v) < $signed(op_b)};
      3'b011:  alu = {31'd0, rs1_v < op_b};
      3'b100:  alu = rs1_v ^ op_b;
      3'b101:  alu = alt ? 32'($signed(rs1_v) >>> op_b[4:0]) : rs1_v >> op_b[4:0];
      3'b110:  alu = rs1_v | op_b;
      default: alu = rs1_v & op_b;
    endcase
  end
  assign cmp  = (f3[2:1] == 2'b00) ? rs1_v == rs2_v :
                (f3[2:1] == 2'b10) ? $signed(rs1_v) < $signed(rs2_v) : rs1_v < rs2_v;
  assign take = (f3[2:1] != 2'b01) & (cmp ^ f3[0]);
  always_comb begin
    pc_d    = pc_q + 32'd4;
    rd_d    = alu;
    rd_we   = 1'b0;
    dmem_we = 1'b0;
    case (opc)
      7'h37: begin rd_we = 1'b1; rd_d = imm_u; end
      7'h17: begin rd_we = 1'b1; rd_d = pc_q + imm_u; end
      7'h6f: begin rd_we = 1'b1; rd_d = pc_q + 32'd4; pc_d = pc_q + imm_j; end
      7'h67: if (f3 == 3'b000) begin
        rd_we = 1'b1;
        rd_d  = pc_q + 32'd4;
        pc_d  = (rs1_v + imm_i) & ~32'd1;
      end
      7'h63: if (take) pc_d = pc_q + imm_b;
      7'h03: if (f3 == 3'b010) begin rd_we = 1'b1; rd_d = dmem_q[ld_idx]; end
      7'h23: dmem_we = f3 == 3'b010;
      7'h13: rd_we = sh_ok;
      7'h33: rd_we = r_ok;
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d & PC_MASK;
      if (rd_we && rd != 5'd0) rf_q[rd] <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (dmem_we) dmem_q[st_idx] <= rs2_v;
  end
  assign reg1  = rf_q[1];
  assign reg2  = rf_q[2];
  assign reg3  = rf_q[3];
  assign reg4  = rf_q[4];
  assign reg5  = rf_q[5];
  assign reg6  = rf_q[6];
  assign reg7  = rf_q[7];
  assign reg8  = rf_q[8];
  assign reg9  = rf_q[9];
  assign reg10 = rf_q[10];
endmodule

// File: tb/tb_system_top_entity.sv
// tb_system_top_entity: loads a directed program into the ROM and checks a hand-derived
// per-edge register trace through a scoreboard queue, including reset behaviour.
module tb_system_top_entity;
   logic clk, reset_n;
   logic [31:0] reg1, reg2, reg3, reg4, reg5, reg6, reg7, reg8, reg9, reg10;
   int checks = 0;
   int failures = 0;

   typedef struct { int rd; logic [31:0] v; } sb_t;
   sb_t sb[$];
   logic [31:0] shadow [1:10];

   // One entry per edge: register written (0 = no visible change) and its new value.
   int t_rd[60] = '{1, 2, 3, 4, 5, 5, 0, 6, 10, 7,
                    8, 8, 0, 8, 0, 8, 0, 9, 0, 0,
                    1, 7, 8, 8, 0, 8, 0, 8, 0, 9,
                    0, 0, 3, 4, 8, 9, 6, 7, 8, 9,
                    10, 1, 2, 3, 4, 5, 6, 0, 0, 0,
                    0, 0, 7, 8, 9, 10, 0, 0, 0, 0};
   logic [31:0] t_v[60] = '{32'h5, 32'hFFFFFFFD, 32'h2, 32'h8, 32'h12345000,
                            32'h12345678, 32'h0, 32'h12345678, 32'h24, 32'hFFFFFFFE,
                            32'h3, 32'h2, 32'h0, 32'h1, 32'h0,
                            32'h0, 32'h0, 32'h7, 32'h0, 32'h0,
                            32'h63, 32'hFFFFFFFE, 32'h3, 32'h2, 32'h0,
                            32'h1, 32'h0, 32'h0, 32'h0, 32'h7,
                            32'h0, 32'h0, 32'h1, 32'h0, 32'h1,
                            32'h1, 32'hEDCBA987, 32'hFFFFFFFF, 32'h78, 32'h7B,
                            32'h701, 32'h7B0, 32'hF, 32'h003D8000, 32'hFFFFDB97,
                            32'h0001DB97, 32'h1080, 32'h0, 32'h0, 32'h0,
                            32'h0, 32'h0, 32'hFFFFDB97, 32'hFFC28000, 32'hB0,
                            32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0};

   system_top_entity #(.IMEM_WORDS(256), .DMEM_WORDS(256), .IMEM_INIT("")) dut (
      .clk(clk), .reset(reset_n),
      .reg1(reg1), .reg2(reg2), .reg3(reg3), .reg4(reg4), .reg5(reg5),
      .reg6(reg6), .reg7(reg7), .reg8(reg8), .reg9(reg9), .reg10(reg10)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ei(input int imm, input int rs1, input int f3, input int rd, input int op);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
   endfunction
   function automatic logic [31:0] er(input int f7, input int rs2, input int rs1, input int f3, input int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
   endfunction
   function automatic logic [31:0] es(input int imm, input int rs2, input int rs1);
      return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] eb(input int imm, input int rs2, input int rs1, input int f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] eu(input int imm, input int rd, input int op);
      return {imm[19:0], rd[4:0], op[6:0]};
   endfunction
   function automatic logic [31:0] ej(input int imm, input int rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
   endfunction

   task automatic put(input int addr, input logic [31:0] w);
      dut.imem[addr >> 2] = w;
   endtask

   function automatic logic [319:0] outs();
      return {reg10, reg9, reg8, reg7, reg6, reg5, reg4, reg3, reg2, reg1};
   endfunction

   function automatic logic [319:0] expv();
      logic [319:0] r;
      for (int k = 1; k <= 10; k++) r[k*32-1 -: 32] = shadow[k];
      return r;
   endfunction

   task automatic check(input string tag);
      logic [319:0] o, e;
      o = outs();
      e = expv();
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s: got %h expected %h", tag, o, e);
      end
   endtask

   task automatic clear_shadow();
      for (int k = 1; k <= 10; k++) shadow[k] = '0;
   endtask

   task automatic run(input int n);
      sb_t e;
      for (int i = 0; i < n; i++) begin
         sb.push_back('{t_rd[i], t_v[i]});
         @(posedge clk);
         #1;
         e = sb.pop_front();
         if (e.rd != 0) shadow[e.rd] = e.v;
         check($sformatf("step%0d", i + 1));
      end
   endtask

   initial begin
      reset_n = 1'b1;
      clear_shadow();
      #1 reset_n = 1'b0;
      put('h00, ei(5, 0, 0, 1, 'h13));
      put('h04, ei(-3, 0, 0, 2, 'h13));
      put('h08, er(0, 2, 1, 0, 3));
      put('h0C, er('h20, 2, 1, 0, 4));
      put('h10, eu('h12345, 5, 'h37));
      put('h14, ei('h678, 5, 0, 5, 'h13));
      put('h18, es(8, 5, 0));
      put('h1C, ei(8, 0, 2, 6, 'h03));
      put('h20, ej(8, 10));
      put('h24, ei(99, 0, 0, 1, 'h13));
      put('h28, ei('h401, 2, 5, 7, 'h13));
      put('h2C, ei(3, 0, 0, 8, 'h13));
      put('h30, ei(-1, 8, 0, 8, 'h13));
      put('h34, eb(-4, 0, 8, 1));
      put('h38, ei(7, 0, 0, 9, 'h13));
      put('h3C, eb(8, 1, 4, 4));
      put('h40, ei(0, 10, 0, 0, 'h67));
      put('h44, 32'h0000_0073);
      put('h48, er(0, 1, 2, 2, 3));
      put('h4C, er(0, 1, 2, 3, 4));
      put('h50, ei(-2, 2, 2, 8, 'h13));
      put('h54, ei(-1, 1, 3, 9, 'h13));
      put('h58, ei(-1, 5, 4, 6, 'h13));
      put('h5C, er(0, 6, 5, 4, 7));
      put('h60, ei('hFF, 5, 7, 8, 'h13));
      put('h64, er(0, 8, 1, 6, 9));
      put('h68, ei('h700, 3, 6, 10, 'h13));
      put('h6C, ei(4, 9, 1, 1, 'h13));
      put('h70, ei(28, 2, 5, 2, 'h13));
      put('h74, er(0, 2, 9, 1, 3));
      put('h78, er('h20, 2, 6, 5, 4));
      put('h7C, er(0, 2, 6, 5, 5));
      put('h80, eu(1, 6, 'h17));
      put('h84, eb(8, 1, 2, 6));
      put('h88, ei(1, 0, 0, 7, 'h13));
      put('h8C, eb(8, 1, 2, 5));
      put('h90, eb(8, 1, 4, 7));
      put('h94, ei(2, 0, 0, 7, 'h13));
      put('h98, eb(8, 0, 0, 0));
      put('h9C, ei(3, 0, 0, 7, 'h13));
      put('hA0, es(-4, 4, 1));
      put('hA4, ei('h3AC, 0, 2, 7, 'h03));
      put('hA8, er('h20, 3, 0, 0, 8));
      put('hAC, ei(5, 10, 0, 9, 'h67));
      put('h304, ei(-1, 0, 0, 10, 'h13));
      put('h308, 32'hFFFF_FFFF);
      put('h30C, ej(0, 0));
      #1 check("rst_async");
      repeat (3) begin
         @(posedge clk);
         #1 check("rst_hold");
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1 check("rst_release");
      run(14);
      #3 reset_n = 1'b0;
      clear_shadow();
      #1 check("mid_rst_async");
      repeat (2) begin
         @(posedge clk);
         #1 check("mid_rst_hold");
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1 check("mid_rst_release");
      run(60);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
